// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data SRAM responder: MMIO offsets,
// default MMIO base, read-source tag and the byte-lane merge function.
package data_sram_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hBFAF_0000;

  localparam logic [15:0] LED_OFF     = 16'h0000;
  localparam logic [15:0] SWITCH_OFF  = 16'h0004;
  localparam logic [15:0] TIMER_OFF   = 16'h0008;
  localparam logic [15:0] SCRATCH_OFF = 16'h000C;
  localparam logic [15:0] NUM_OFF     = 16'h0010;

  typedef enum logic {
    SRC_RAM  = 1'b0,
    SRC_MMIO = 1'b1
  } rd_src_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) begin
        merged[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data SRAM bus: request (en/wen/addr/wdata) from the core, rdata back.
interface data_sram_responder_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, wen, addr, wdata, input rdata);
  modport slave  (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/data_sram_responder_sram_word_ram.sv
// Word-wide synchronous RAM with per-byte write enables and a registered,
// resettable read port; the array itself is never reset.
module sram_word_ram
  import data_sram_responder_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;

  // array write: untouched lanes keep their previous contents
  always_ff @(posedge clk) begin
    if (|we_i) begin
      mem[addr_i] <= byte_merge(mem[addr_i], wdata_i, we_i);
    end
  end

  // read register holds between reads so the bus sees a stable value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0000_0000;
    end else if (rd_en_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data SRAM bus: word RAM plus a small MMIO block
// (LED, switch, timer, scratch, numeric display) with 1-cycle read latency.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic                        clk,
  input  logic                        resetn,
  data_sram_responder_if.slave        bus,
  input  logic [15:0]                 switch,
  output logic [15:0]                 led,
  output logic [31:0]                 num_data
);

  logic        mmio_hit_s, rd_req_s, wr_req_s, wr_mmio_s, ram_rd_s;
  logic [15:0] off_s;
  logic [3:0]  ram_we_s;
  logic [31:0] ram_rdata_s, mmio_rd_s;

  logic [15:0] led_q, led_d;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] num_q, num_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  rd_src_e     src_q, src_d;

  // address decode and request classification
  always_comb begin
    mmio_hit_s = (bus.addr[31:16] == MMIO_BASE[31:16]);
    off_s      = bus.addr[15:0];
    rd_req_s   = bus.en && (bus.wen == 4'h0);
    wr_req_s   = bus.en && (bus.wen != 4'h0);
    wr_mmio_s  = wr_req_s && mmio_hit_s;
    ram_rd_s   = rd_req_s && !mmio_hit_s;
    if (wr_req_s && !mmio_hit_s && resetn) begin
      ram_we_s = bus.wen;
    end else begin
      ram_we_s = 4'h0;
    end
  end

  sram_word_ram #(.AW(RAM_AW)) u_ram (
    .clk     (clk),
    .rst_n   (resetn),
    .rd_en_i (ram_rd_s),
    .we_i    (ram_we_s),
    .addr_i  (bus.addr[RAM_AW+1:2]),
    .wdata_i (bus.wdata),
    .rdata_o (ram_rdata_s)
  );

  // MMIO read mux, sampled as of the request cycle
  always_comb begin
    case (off_s)
      LED_OFF:     mmio_rd_s = {16'h0000, led_q};
      SWITCH_OFF:  mmio_rd_s = {16'h0000, sw_sync_q};
      TIMER_OFF:   mmio_rd_s = timer_q;
      SCRATCH_OFF: mmio_rd_s = scratch_q;
      NUM_OFF:     mmio_rd_s = num_q;
      default:     mmio_rd_s = 32'h0000_0000;
    endcase
  end

  // register next-state; a timer write replaces that cycle's increment
  always_comb begin
    led_d        = led_q;
    scratch_d    = scratch_q;
    num_d        = num_q;
    timer_d      = timer_q + 32'd1;
    src_d        = src_q;
    mmio_rdata_d = mmio_rdata_q;
    if (rd_req_s) begin
      src_d        = mmio_hit_s ? SRC_MMIO : SRC_RAM;
      mmio_rdata_d = mmio_rd_s;
    end else begin
      src_d        = src_q;
      mmio_rdata_d = mmio_rdata_q;
    end
    if (wr_mmio_s) begin
      case (off_s)
        LED_OFF: begin
          led_d[7:0]  = bus.wen[0] ? bus.wdata[7:0]  : led_q[7:0];
          led_d[15:8] = bus.wen[1] ? bus.wdata[15:8] : led_q[15:8];
        end
        TIMER_OFF:   timer_d   = byte_merge(timer_q, bus.wdata, bus.wen);
        SCRATCH_OFF: scratch_d = byte_merge(scratch_q, bus.wdata, bus.wen);
        NUM_OFF:     num_d     = byte_merge(num_q, bus.wdata, bus.wen);
        default:     led_d     = led_q;
      endcase
    end else begin
      led_d = led_q;
    end
  end

  // state registers and switch synchroniser
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q        <= 16'h0000;
      sw_meta_q    <= 16'h0000;
      sw_sync_q    <= 16'h0000;
      timer_q      <= 32'h0000_0000;
      scratch_q    <= 32'h0000_0000;
      num_q        <= 32'h0000_0000;
      mmio_rdata_q <= 32'h0000_0000;
      src_q        <= SRC_RAM;
    end else begin
      led_q        <= led_d;
      sw_meta_q    <= switch;
      sw_sync_q    <= sw_meta_q;
      timer_q      <= timer_d;
      scratch_q    <= scratch_d;
      num_q        <= num_d;
      mmio_rdata_q <= mmio_rdata_d;
      src_q        <= src_d;
    end
  end

  assign bus.rdata = (src_q == SRC_MMIO) ? mmio_rdata_q : ram_rdata_s;
  assign led       = led_q;
  assign num_data  = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized self-checking bench for data_sram_responder against a
// cycle-level behavioural model of the SRAM/MMIO map.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] sw;
  logic [15:0] led;
  logic [31:0] num;

  data_sram_responder_if bus();

  data_sram_responder #(.RAM_AW(12), .MMIO_BASE(32'hBFAF_0000)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .switch   (sw),
    .led      (led),
    .num_data (num)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  logic [31:0] m_mem [4096];
  logic [15:0] m_led, m_sw1, m_sw2;
  logic [31:0] m_timer, m_scratch, m_num, m_rdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] w);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:16] == 16'hBFAF) begin
      case (a[15:0])
        16'h0000: return {16'h0000, m_led};
        16'h0004: return {16'h0000, m_sw2};
        16'h0008: return m_timer;
        16'h000C: return m_scratch;
        16'h0010: return m_num;
        default:  return 32'h0000_0000;
      endcase
    end
    return m_mem[a[13:2]];
  endfunction

  task automatic model_reset();
    m_led = 16'h0; m_sw1 = 16'h0; m_sw2 = 16'h0;
    m_timer = 32'h0; m_scratch = 32'h0; m_num = 32'h0; m_rdata = 32'h0;
  endtask

  // apply one rising edge worth of behaviour, using pre-edge values
  task automatic model_edge(input logic en, input logic [3:0] wen,
                            input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] t_next, tmp;
    logic [31:0] r_next;
    r_next = m_rdata;
    t_next = m_timer + 32'd1;
    if (en && wen == 4'h0) r_next = m_read(a);
    if (en && wen != 4'h0) begin
      if (a[31:16] == 16'hBFAF) begin
        case (a[15:0])
          16'h0000: begin tmp = lane_merge({16'h0, m_led}, wd, wen & 4'b0011); m_led = tmp[15:0]; end
          16'h0008: t_next = lane_merge(m_timer, wd, wen);
          16'h000C: m_scratch = lane_merge(m_scratch, wd, wen);
          16'h0010: m_num = lane_merge(m_num, wd, wen);
          default: ;
        endcase
      end else begin
        m_mem[a[13:2]] = lane_merge(m_mem[a[13:2]], wd, wen);
      end
    end
    m_timer = t_next;
    m_sw2   = m_sw1;
    m_sw1   = sw;
    m_rdata = r_next;
  endtask

  task automatic step(input logic en, input logic [3:0] wen,
                      input logic [31:0] a, input logic [31:0] wd);
    bus.en = en; bus.wen = wen; bus.addr = a; bus.wdata = wd;
    model_edge(en, wen, a, wd);
    @(posedge clk);
    #1;
    check_eq("rdata", bus.rdata, m_rdata);
    check_eq("led", {16'h0, led}, {16'h0, m_led});
    check_eq("num_data", num, m_num);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  w;
    int          offs [7];
    offs = '{0, 4, 8, 12, 16, 20, 32};
    resetn = 1'b0; sw = 16'h0;
    bus.en = 1'b0; bus.wen = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
    model_reset();
    #12;
    check_eq("rst_rdata", bus.rdata, 32'h0);
    check_eq("rst_led", {16'h0, led}, 32'h0);
    check_eq("rst_num", num, 32'h0);
    resetn = 1'b1;

    // preload the RAM window used by random traffic
    for (int i = 0; i < 32; i++) step(1'b1, 4'hF, 32'(i) << 2, $urandom);

    step(1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678);
    check_eq("rdata_before_read", bus.rdata, 32'h0);
    step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check_eq("ram_full_word", bus.rdata, 32'h1234_5678);
    step(1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD);
    step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check_eq("ram_partial", bus.rdata, 32'h12BB_56DD);
    step(1'b1, 4'hF, 32'h0000_4000, 32'hCAFE_F00D);
    step(1'b1, 4'h0, 32'h0000_0000, 32'h0);
    check_eq("ram_alias", bus.rdata, 32'hCAFE_F00D);

    step(1'b1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFE);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
    check_eq("timer_max", bus.rdata, 32'hFFFF_FFFF);
    step(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
    check_eq("timer_wrap", bus.rdata, 32'h0);

    step(1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_A5A5);
    check_eq("led_out", {16'h0, led}, 32'h0000_A5A5);
    step(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
    check_eq("led_read", bus.rdata, 32'h0000_A5A5);

    sw = 16'h00F0;
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
    check_eq("switch_read", bus.rdata, 32'h0000_00F0);

    step(1'b1, 4'hF, 32'hBFAF_0020, 32'h0000_0001);
    step(1'b1, 4'h0, 32'hBFAF_0020, 32'h0);
    check_eq("unmapped_read", bus.rdata, 32'h0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
      w = 4'($urandom_range(1, 15));
      wd = $urandom;
      case ($urandom_range(0, 4))
        0: step(1'b1, w, ($urandom & 32'h0FFF_C000) | (32'($urandom_range(0, 31)) << 2)
                          | 32'($urandom_range(0, 3)), wd);
        1: step(1'b1, 4'h0, ($urandom & 32'h0FFF_C000) | (32'($urandom_range(0, 31)) << 2), 32'h0);
        2: step(1'b1, w, 32'hBFAF_0000 | 32'(offs[$urandom_range(0, 6)]), wd);
        3: step(1'b1, 4'h0, 32'hBFAF_0000 | 32'(offs[$urandom_range(0, 6)]), 32'h0);
        default: step(1'b0, w, $urandom, wd);
      endcase
    end

    // asynchronous reset between edges with non-zero state
    step(1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_1234);
    step(1'b1, 4'hF, 32'hBFAF_0010, 32'h5555_AAAA);
    step(1'b1, 4'h0, 32'hBFAF_0010, 32'h0);
    bus.en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check_eq("arst_led", {16'h0, led}, 32'h0);
    check_eq("arst_num", num, 32'h0);
    check_eq("arst_rdata", bus.rdata, 32'h0);
    model_reset();
    #2 resetn = 1'b1;
    step(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
    check_eq("timer_restart0", bus.rdata, 32'h0);
    step(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
    check_eq("timer_restart1", bus.rdata, 32'h1);
    for (int i = 0; i < 32; i++) step(1'b1, 4'h0, 32'(i) << 2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
